// File: rtl/trb_bus_pkg.sv
// ============================================================================
// trb_bus_pkg: bus word geometry, field offsets and packer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package trb_bus_pkg;

  localparam int BUS           = 534;
  localparam int ST            = 8;
  localparam int BYTES_PER_BUS = 64;
  localparam int SEQ_W         = 12;
  localparam int PAY_W         = 512;
  localparam int CNT_W         = 7;

  localparam int PAY_LSB = 0;
  localparam int CNT_LSB = 512;
  localparam int SOP_BIT = 519;
  localparam int EOP_BIT = 520;
  localparam int ERR_BIT = 521;
  localparam int SEQ_LSB = 522;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  function automatic logic [BUS-1:0] pack_word(
    input logic [PAY_W-1:0] pay,
    input logic [CNT_W-1:0] cnt,
    input logic             sop,
    input logic             eop,
    input logic             err,
    input logic [SEQ_W-1:0] seq
  );
    logic [BUS-1:0] w;
    w                    = '0;
    w[PAY_LSB +: PAY_W]  = pay;
    w[CNT_LSB +: CNT_W]  = cnt;
    w[SOP_BIT]           = sop;
    w[EOP_BIT]           = eop;
    w[ERR_BIT]           = err;
    w[SEQ_LSB +: SEQ_W]  = seq;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/st2bus_obuf.sv
// ============================================================================
// st2bus_obuf: single-word output register with bus_en/bus_ready handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module st2bus_obuf
  import trb_bus_pkg::*;
(
  input  logic           clk_bus,
  input  logic           rst_n,
  input  logic           load,
  input  logic [BUS-1:0] word,
  input  logic           bus_ready,
  output logic [BUS-1:0] bus_data,
  output logic           bus_en,
  output logic           full
);

  assign bus_en = full && bus_ready;

  // A load may coincide with a drain; the new word replaces the departing one.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      bus_data <= '0;
      full     <= 1'b0;
    end else if (load) begin
      bus_data <= word;
      full     <= 1'b1;
    end else if (bus_en) begin
      full     <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/st2bus_pack.sv
// ============================================================================
// st2bus_pack: packs the 8-bit packet stream into 534-bit host bus words
// Rev 1.0 -- define ST2BUS_SEQNUM_EN to carry the packet sequence number
// ============================================================================
`default_nettype none

module st2bus_pack
  import trb_bus_pkg::*;
(
  input  logic           clk_bus,
  input  logic           rst_n,
  input  logic [ST-1:0]  st_data,
  input  logic           st_valid,
  input  logic           st_sop,
  input  logic           st_eop,
  output logic           st_ready,
  output logic [BUS-1:0] bus_data,
  output logic           bus_en,
  input  logic           bus_ready,
  output logic [15:0]    drop_cnt
);

  state_t           state, state_nxt;
  logic [PAY_W-1:0] acc_pay, acc_pay_nxt, app_pay;
  logic [CNT_W-1:0] acc_cnt, acc_cnt_nxt, app_cnt;
  logic             acc_sop, acc_sop_nxt, acc_eop, acc_eop_nxt;
  logic             up, drop, load, accept;
  logic             obuf_full, obuf_free, mid_sop_stall;
  logic [BUS-1:0]   load_word;
  logic [SEQ_W-1:0] seq;

`ifdef ST2BUS_SEQNUM_EN
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n)
      seq <= '0;
    else if (load && load_word[EOP_BIT])
      seq <= seq + 1'b1;
  end
`else
  assign seq = '0;
`endif

  assign obuf_free     = !obuf_full || bus_ready;
  // A sop that aborts a partial word needs the obuf for that word and the accumulator for itself.
  assign mid_sop_stall = (state == S_PKT) && st_sop && (acc_cnt != '0) && !obuf_free;
  assign st_ready      = up && (state != S_HOLD) && !mid_sop_stall;
  assign accept        = st_valid && st_ready;

  always_comb begin
    state_nxt   = state;
    acc_pay_nxt = acc_pay;
    acc_cnt_nxt = acc_cnt;
    acc_sop_nxt = acc_sop;
    acc_eop_nxt = acc_eop;
    load        = 1'b0;
    load_word   = '0;
    drop        = 1'b0;
    app_pay     = acc_pay;
    app_pay[{acc_cnt[5:0], 3'b000} +: ST] = st_data;
    app_cnt     = acc_cnt + 1'b1;

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (st_sop) begin
            acc_pay_nxt = {{(PAY_W-ST){1'b0}}, st_data};
            acc_cnt_nxt = 7'd1;
            acc_sop_nxt = 1'b1;
            acc_eop_nxt = st_eop;
            if (!st_eop) begin
              state_nxt = S_PKT;
            end else if (obuf_free) begin
              load        = 1'b1;
              load_word   = pack_word({{(PAY_W-ST){1'b0}}, st_data}, 7'd1, 1'b1, 1'b1, 1'b0, seq);
              acc_pay_nxt = '0;
              acc_cnt_nxt = '0;
              acc_sop_nxt = 1'b0;
              acc_eop_nxt = 1'b0;
            end else begin
              state_nxt = S_HOLD;
            end
          end else begin
            drop = 1'b1;
          end
        end
      end

      S_PKT: begin
        if (accept) begin
          if (st_sop) begin
            // An empty accumulator means the abort has no partial word to flush.
            if (acc_cnt != '0) begin
              load      = 1'b1;
              load_word = pack_word(acc_pay, acc_cnt, acc_sop, 1'b1, 1'b1, seq);
            end
            acc_pay_nxt = {{(PAY_W-ST){1'b0}}, st_data};
            acc_cnt_nxt = 7'd1;
            acc_sop_nxt = 1'b1;
            acc_eop_nxt = st_eop;
            state_nxt   = st_eop ? S_HOLD : S_PKT;
          end else if ((app_cnt == CNT_W'(BYTES_PER_BUS)) || st_eop) begin
            if (obuf_free) begin
              load        = 1'b1;
              load_word   = pack_word(app_pay, app_cnt, acc_sop, st_eop, 1'b0, seq);
              acc_pay_nxt = '0;
              acc_cnt_nxt = '0;
              acc_sop_nxt = 1'b0;
              acc_eop_nxt = 1'b0;
              state_nxt   = st_eop ? S_IDLE : S_PKT;
            end else begin
              acc_pay_nxt = app_pay;
              acc_cnt_nxt = app_cnt;
              acc_eop_nxt = st_eop;
              state_nxt   = S_HOLD;
            end
          end else begin
            acc_pay_nxt = app_pay;
            acc_cnt_nxt = app_cnt;
          end
        end
      end

      S_HOLD: begin
        if (obuf_free) begin
          load        = 1'b1;
          load_word   = pack_word(acc_pay, acc_cnt, acc_sop, acc_eop, 1'b0, seq);
          acc_pay_nxt = '0;
          acc_cnt_nxt = '0;
          acc_sop_nxt = 1'b0;
          acc_eop_nxt = 1'b0;
          state_nxt   = acc_eop ? S_IDLE : S_PKT;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc_pay  <= '0;
      acc_cnt  <= '0;
      acc_sop  <= 1'b0;
      acc_eop  <= 1'b0;
      up       <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      acc_pay  <= acc_pay_nxt;
      acc_cnt  <= acc_cnt_nxt;
      acc_sop  <= acc_sop_nxt;
      acc_eop  <= acc_eop_nxt;
      up       <= 1'b1;
      if (drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  st2bus_obuf u_obuf (
    .clk_bus   (clk_bus),
    .rst_n     (rst_n),
    .load      (load),
    .word      (load_word),
    .bus_ready (bus_ready),
    .bus_data  (bus_data),
    .bus_en    (bus_en),
    .full      (obuf_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_st2bus_pack.sv
// ============================================================================
// tb_st2bus_pack: randomized and directed bench with a packet-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_st2bus_pack;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } beat_t;

`ifdef ST2BUS_SEQNUM_EN
  localparam logic [11:0] SEQ_MASK = 12'hFFF;
`else
  localparam logic [11:0] SEQ_MASK = 12'h000;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   st_data;
  logic         st_valid, st_sop, st_eop, st_ready;
  logic [533:0] bus_data;
  logic         bus_en, bus_ready;
  logic [15:0]  drop_cnt;

  int           checks = 0;
  int           errors = 0;
  int           rdy_mode = 0;
  int           vprob = 100;
  bit           last_acc, last_en;

  beat_t        stim_q[$];
  logic [533:0] exp_q[$];
  logic [533:0] obs_q[$];
  logic [7:0]   m_cur[$];
  logic [11:0]  m_seq;
  logic         m_in_pkt, m_first;
  logic [15:0]  m_drops;

  always #5 clk = ~clk;

  st2bus_pack dut (
    .clk_bus   (clk),
    .rst_n     (rst_n),
    .st_data   (st_data),
    .st_valid  (st_valid),
    .st_sop    (st_sop),
    .st_eop    (st_eop),
    .st_ready  (st_ready),
    .bus_data  (bus_data),
    .bus_en    (bus_en),
    .bus_ready (bus_ready),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [533:0] obs, input logic [533:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] hdr(input logic [11:0] s, input logic er, input logic eo,
                                      input logic so, input logic [6:0] c);
    return {s & SEQ_MASK, er, eo, so, c};
  endfunction

  // Reference model: byte-level packet rules, words built from a byte queue.
  task automatic model_reset();
    m_cur.delete();
    exp_q.delete();
    m_seq    = '0;
    m_in_pkt = 1'b0;
    m_first  = 1'b0;
    m_drops  = '0;
  endtask

  task automatic emit(input logic e, input logic er);
    logic [533:0] w;
    w = '0;
    for (int k = 0; k < m_cur.size(); k++) w[8*k +: 8] = m_cur[k];
    w[533:512] = hdr(m_seq, er, e, m_first, 7'(m_cur.size()));
    exp_q.push_back(w);
  endtask

  task automatic model_beat(input logic [7:0] d, input logic s, input logic e);
    if (!m_in_pkt) begin
      if (!s) begin
        if (m_drops != 16'hFFFF) m_drops++;
        return;
      end
      m_in_pkt = 1'b1;
    end else if (s) begin
      if (m_cur.size() > 0) begin
        emit(1'b1, 1'b1);
        m_seq++;
      end
    end
    if (s) begin
      m_first = 1'b1;
      m_cur.delete();
    end
    m_cur.push_back(d);
    if (m_cur.size() == 64 || e) begin
      emit(e, 1'b0);
      m_first = 1'b0;
      m_cur.delete();
      if (e) begin
        m_seq++;
        m_in_pkt = 1'b0;
      end
    end
  endtask

  task automatic push_beat(input logic [7:0] d, input logic s, input logic e);
    stim_q.push_back({d, s, e});
  endtask

  task automatic push_pkt(input int len, input bit seq_data, input bit trunc);
    for (int i = 0; i < len; i++)
      push_beat(seq_data ? 8'(i) : 8'($urandom), i == 0, (i == len - 1) && !trunc);
  endtask

  task automatic drive();
    case (rdy_mode)
      0:       bus_ready = 1'b1;
      1:       bus_ready = 1'b0;
      default: bus_ready = 1'($urandom_range(1));
    endcase
    if (stim_q.size() > 0) begin
      st_valid = ($urandom_range(99) < vprob);
      st_data  = stim_q[0].d;
      st_sop   = stim_q[0].s;
      st_eop   = stim_q[0].e;
    end else begin
      st_valid = 1'b0;
      st_data  = '0;
      st_sop   = 1'b0;
      st_eop   = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    last_acc = st_valid && st_ready;
    last_en  = bus_en;
    if (bus_en) begin
      obs_q.push_back(bus_data);
      if (exp_q.size() == 0) chk("spurious_word", bus_data, '0);
      else                   chk("word", bus_data, exp_q.pop_front());
    end
    @(posedge clk);
    if (last_acc) begin
      model_beat(st_data, st_sop, st_eop);
      void'(stim_q.pop_front());
    end
    #1 drive();
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && n < max) begin
      step();
      n++;
    end
    if (n >= max) chk("drain_timeout", 534'(stim_q.size() + exp_q.size()), '0);
    repeat (3) step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [533:0] w;
    logic [11:0]  s0;
    int           cnt, junk, len;
    bit           trunc;

    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_sop    = 1'b0;
    st_eop    = 1'b0;
    st_data   = '0;
    bus_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_st_ready", st_ready, 0);
    chk("rst_bus_en", bus_en, 0);
    chk("rst_bus_data", bus_data, '0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", st_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_edge", st_ready, 1);

    // 128-byte packet, bus always ready
    obs_q.delete();
    push_pkt(128, 1, 0);
    drain(1000);
    chk("t1_nwords", obs_q.size(), 2);
    w = obs_q[0];
    chk("t1_w0_hdr", w[533:512], hdr(12'd0, 0, 0, 1, 7'd64));
    w = obs_q[1];
    chk("t1_w1_hdr", w[533:512], hdr(12'd0, 0, 1, 0, 7'd64));

    // 65-byte packet: one-byte tail word
    obs_q.delete();
    push_pkt(65, 1, 0);
    drain(1000);
    chk("t2_nwords", obs_q.size(), 2);
    w = obs_q[1];
    chk("t2_w1_hdr", w[533:512], hdr(12'd1, 0, 1, 0, 7'd1));
    chk("t2_w1_byte0", w[7:0], 8'd64);
    chk("t2_w1_unused", w[511:8], '0);

    // single-byte packet and eop-to-bus_en latency
    obs_q.delete();
    push_beat(8'hA5, 1, 1);
    cnt = 0;
    do begin step(); cnt++; end while (!last_acc && cnt < 20);
    step();
    chk("t3_latency", last_en, 1);
    drain(100);
    w = obs_q[0];
    chk("t3_word", w, {hdr(12'd2, 0, 1, 1, 7'd1), 504'd0, 8'hA5});
    obs_q.delete();
    push_pkt(5, 0, 0);
    drain(100);
    w = obs_q[0];
    chk("t3_next_seq", w[533:512], hdr(12'd3, 0, 1, 1, 7'd5));

    // bus stalled: at most 128 bytes buffered, nothing lost afterwards
    obs_q.delete();
    rdy_mode = 1;
    push_pkt(200, 0, 0);
    cnt = 0;
    repeat (300) begin
      step();
      if (last_acc) cnt++;
    end
    chk("t4_accepted", cnt, 128);
    chk("t4_ready_low", st_ready, 0);
    chk("t4_no_words", obs_q.size(), 0);
    rdy_mode = 0;
    drain(2000);
    chk("t4_nwords", obs_q.size(), 4);

    // drops outside a packet, then a sop that aborts an open packet
    for (int i = 0; i < 3; i++) push_beat(8'($urandom), 0, 0);
    push_pkt(20, 0, 0);
    drain(500);
    chk("t5_drop_cnt", drop_cnt, 3);
    obs_q.delete();
    s0 = m_seq;
    push_pkt(10, 0, 1);
    push_pkt(5, 0, 0);
    drain(500);
    chk("t5_nwords", obs_q.size(), 2);
    w = obs_q[0];
    chk("t5_err_hdr", w[533:512], hdr(s0, 1, 1, 1, 7'd10));

    // randomized traffic with random back-pressure and valid gaps
    rdy_mode = 2;
    vprob    = 70;
    for (int p = 0; p < 40; p++) begin
      junk  = ($urandom_range(5) == 0) ? $urandom_range(3, 1) : 0;
      len   = $urandom_range(150, 1);
      trunc = ($urandom_range(7) == 0);
      for (int j = 0; j < junk; j++) push_beat(8'($urandom), 0, 1'($urandom_range(1)));
      push_pkt(len, 0, trunc);
    end
    push_pkt(30, 0, 0);
    drain(40000);
    chk("t6_drop_cnt", drop_cnt, m_drops);

    // reset in the middle of a packet
    rdy_mode = 0;
    vprob    = 100;
    obs_q.delete();
    push_pkt(100, 0, 0);
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 30; i++) begin
      step();
      if (last_acc) cnt++;
    end
    #2 rst_n = 1'b0;
    stim_q.delete();
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    model_reset();
    #1;
    chk("t7_rst_ready", st_ready, 0);
    chk("t7_rst_data", bus_data, '0);
    chk("t7_rst_drop", drop_cnt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t7_rst_bus_en", bus_en, 0);
    rst_n = 1'b1;
    push_pkt(10, 0, 0);
    drain(500);
    chk("t7_nwords", obs_q.size(), 1);
    w = obs_q[0];
    chk("t7_hdr", w[533:512], hdr(12'd0, 0, 1, 1, 7'd10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
